// File: rtl/key_events_pkg.sv
// Shared types and helpers for the multi-key debounce / click classifier.
package key_events_pkg;

    // Per-channel classifier states
    typedef enum logic [3:0] {
        IDLE,
        PDB,
        HOLD,
        LHOLD,
        RDB,
        RDB_L,
        GAP,
        HOLD2,
        RDB2
    } state_t;

    // Pin level that means "not pressed" for each polarity
    localparam logic PIN_RELEASED_ACTIVE_LOW  = 1'b1;
    localparam logic PIN_RELEASED_ACTIVE_HIGH = 1'b0;

    // Released pin level for the selected polarity
    function automatic logic released_level(input bit active_low);
        return active_low ? PIN_RELEASED_ACTIVE_LOW : PIN_RELEASED_ACTIVE_HIGH;
    endfunction

    // Counter width able to reach the largest timing threshold
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/key_events_if.sv
// Key pins in, debounced level and event pulses out.
interface key_events_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key;
    logic [N_KEYS-1:0] held;
    logic [N_KEYS-1:0] click;
    logic [N_KEYS-1:0] dclick;
    logic [N_KEYS-1:0] lpress;

    modport master (output key, input held, input click, input dclick, input lpress);
    modport slave  (input key, output held, output click, output dclick, output lpress);
endinterface

// File: rtl/key_events_ch.sv
// One key channel: 2-FF synchronizer, polarity normalise, classifier FSM.
module key_events_ch
    import key_events_pkg::*;
#(
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int GAP_CYC      = 25_000_000,
    parameter int DCLICK_EN    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic held,
    output logic click,
    output logic dclick,
    output logic lpress
);
    localparam int            CW        = cnt_width(LONG_CYC, GAP_CYC, DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic          REL_LVL   = released_level(ACTIVE_LOW != 0);

    logic          s1, s2, p;
    state_t        state;
    logic [CW-1:0] cnt;       // time in current state, cleared on entry
    logic [CW-1:0] hold_cnt;  // accumulated hold time, survives release glitches
    logic          second;    // current press is the second of a pair
    logic          lp_pend;   // lpress owed one cycle after a HOLD2 long press

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign p = (ACTIVE_LOW != 0) ? ~s2 : s2;

    // Bring the raw pin into the clock domain; reset to the released level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= REL_LVL;
            s2 <= REL_LVL;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

    // Classifier FSM with registered level and one-cycle event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hold_cnt <= '0;
            second   <= 1'b0;
            lp_pend  <= 1'b0;
            held     <= 1'b0;
            click    <= 1'b0;
            dclick   <= 1'b0;
            lpress   <= 1'b0;
        end else begin
            click   <= 1'b0;
            dclick  <= 1'b0;
            lpress  <= lp_pend;
            lp_pend <= 1'b0;
            cnt     <= sat_inc(cnt);
            case (state)
                IDLE: begin
                    if (p) begin
                        state  <= PDB;
                        cnt    <= '0;
                        second <= 1'b0;
                    end
                end
                PDB: begin
                    if (cnt == DB_LAST) begin
                        cnt <= '0;
                        if (p) begin
                            held     <= 1'b1;
                            hold_cnt <= '0;
                            state    <= second ? HOLD2 : HOLD;
                        end else begin
                            state <= second ? GAP : IDLE;
                        end
                    end
                end
                HOLD: begin
                    // Reaching the threshold wins over a same-cycle release
                    if (hold_cnt == LONG_LAST) begin
                        lpress <= 1'b1;
                        state  <= LHOLD;
                        cnt    <= '0;
                    end else begin
                        hold_cnt <= sat_inc(hold_cnt);
                        if (!p) begin
                            state <= RDB;
                            cnt   <= '0;
                        end
                    end
                end
                LHOLD: begin
                    if (!p) begin
                        state <= RDB_L;
                        cnt   <= '0;
                    end
                end
                RDB, RDB_L, RDB2: begin
                    if (cnt == DB_LAST) begin
                        cnt <= '0;
                        if (p) begin
                            state <= (state == RDB) ? HOLD : (state == RDB_L) ? LHOLD : HOLD2;
                        end else begin
                            held <= 1'b0;
                            if (state == RDB2) begin
                                dclick <= 1'b1;
                                state  <= IDLE;
                            end else if (state == RDB_L) begin
                                state <= IDLE;
                            end else if (DCLICK_EN == 0) begin
                                click <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    // Expiry wins over a same-cycle rise; that press restarts from IDLE
                    if (cnt == GAP_LAST) begin
                        click <= 1'b1;
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (p) begin
                        state  <= PDB;
                        second <= 1'b1;
                        cnt    <= '0;
                    end
                end
                HOLD2: begin
                    // Second press held long: first press is a click, this one a long press
                    if (hold_cnt == LONG_LAST) begin
                        click   <= 1'b1;
                        lp_pend <= 1'b1;
                        state   <= LHOLD;
                        cnt     <= '0;
                    end else begin
                        hold_cnt <= sat_inc(hold_cnt);
                        if (!p) begin
                            state <= RDB2;
                            cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_events.sv
// N-key debounce and click/double-click/long-press front end; wiring only.
module key_events
    import key_events_pkg::*;
#(
    parameter int N_KEYS       = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int GAP_CYC      = 25_000_000,
    parameter int DCLICK_EN    = 1
) (
    input logic         clk,
    input logic         rst,
    key_events_if.slave bus
);
    logic [N_KEYS-1:0] held_w, click_w, dclick_w, lpress_w;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_events_ch #(
            .ACTIVE_LOW  (ACTIVE_LOW),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC    (LONG_CYC),
            .GAP_CYC     (GAP_CYC),
            .DCLICK_EN   (DCLICK_EN)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .key_raw(bus.key[i]),
            .held   (held_w[i]),
            .click  (click_w[i]),
            .dclick (dclick_w[i]),
            .lpress (lpress_w[i])
        );
    end

    assign bus.held   = held_w;
    assign bus.click  = click_w;
    assign bus.dclick = dclick_w;
    assign bus.lpress = lpress_w;

endmodule
